inst_fifo: RTL and testbench

- Dual-port instruction buffer between the fetch stage and the dual-issue decode/issue stage.
- Fetch pushes 0, 1 or 2 instructions per cycle. Issue pops 0, 1 or 2 per cycle: the master slot always pops first, and the slave slot pops a second entry only when the slave is enabled.
- Provides show-ahead head entries and the empty/almost-empty/full status that the issue controller and fetch stall logic consume.

---
 rtl/inst_fifo.sv | 111 +++++++++++
 tb/tb_inst_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fifo.sv
// Dual-port show-ahead instruction buffer between fetch (0-2 pushes/cycle) and dual issue (0-2 pops/cycle).
// Pushes are visible one cycle later; an overflowing push is dropped whole, over-pops are clamped to count.
module inst_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          write_en1,
  input  logic          write_en2,
  input  logic [DW-1:0] write_inst1,
  input  logic [AW-1:0] write_pc1,
  input  logic          write_adel1,
  input  logic [DW-1:0] write_inst2,
  input  logic [AW-1:0] write_pc2,
  input  logic          write_adel2,
  input  logic          read_en1,
  input  logic          read_en2,
  output logic [DW-1:0] master_inst,
  output logic [AW-1:0] master_pc,
  output logic          master_adel,
  output logic [DW-1:0] slave_inst,
  output logic [AW-1:0] slave_pc,
  output logic          slave_adel,
  output logic          fifo_empty,
  output logic          fifo_almost_empty,
  output logic          fifo_full
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0]    mem_inst [DEPTH];
  logic [AW-1:0]    mem_pc   [DEPTH];
  logic [DEPTH-1:0] mem_adel;

  logic [PW-1:0] rptr, wptr, rptr_p1, wptr_p1;
  logic [PW:0]   count;
  logic [1:0]    wn, rreq, rn, wr_cnt;
  logic [PW+1:0] next_level;
  logic          push_ok;

  assign rptr_p1 = rptr + PW'(1);
  assign wptr_p1 = wptr + PW'(1);

  always_comb begin
    wn   = {1'b0, write_en1} + {1'b0, write_en1 & write_en2};
    rreq = {1'b0, read_en1}  + {1'b0, read_en1 & read_en2};
    rn   = rreq;
    // Clamp the pop so the read pointer can never overtake the write pointer.
    if ((PW+1)'(rreq) > count) rn = count[1:0];
    next_level = (PW+2)'(count) - (PW+2)'(rn) + (PW+2)'(wn);
    push_ok    = next_level <= (PW+2)'(DEPTH);
    wr_cnt     = push_ok ? wn : 2'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + PW'(rn);
      wptr  <= wptr + PW'(wr_cnt);
      count <= count - (PW+1)'(rn) + (PW+1)'(wr_cnt);
    end
  end

  // Storage holds no reset: contents are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (!flush && push_ok && write_en1) begin
      mem_inst[wptr] <= write_inst1;
      mem_pc[wptr]   <= write_pc1;
      mem_adel[wptr] <= write_adel1;
      if (write_en2) begin
        mem_inst[wptr_p1] <= write_inst2;
        mem_pc[wptr_p1]   <= write_pc2;
        mem_adel[wptr_p1] <= write_adel2;
      end
    end
  end

  always_comb begin
    master_inst = '0;
    master_pc   = '0;
    master_adel = 1'b0;
    slave_inst  = '0;
    slave_pc    = '0;
    slave_adel  = 1'b0;
    if (count != '0) begin
      master_inst = mem_inst[rptr];
      master_pc   = mem_pc[rptr];
      master_adel = mem_adel[rptr];
    end
    if (count >= (PW+1)'(2)) begin
      slave_inst = mem_inst[rptr_p1];
      slave_pc   = mem_pc[rptr_p1];
      slave_adel = mem_adel[rptr_p1];
    end
  end

  assign fifo_empty        = (count == '0);
  assign fifo_almost_empty = (count == (PW+1)'(1));
  assign fifo_full         = (count > (PW+1)'(DEPTH - 2));

endmodule

// File: tb/tb_inst_fifo.sv
// Directed and random bench for inst_fifo against a queue-based reference model.
module tb_inst_fifo;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush, write_en1, write_en2, read_en1, read_en2;
  logic [31:0] write_inst1, write_pc1, write_inst2, write_pc2;
  logic        write_adel1, write_adel2;
  logic [31:0] master_inst, master_pc, slave_inst, slave_pc;
  logic        master_adel, slave_adel;
  logic        fifo_empty, fifo_almost_empty, fifo_full;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  logic [31:0] pushed[$];
  logic [31:0] popped[$];
  bit          rec = 1'b0;
  logic [31:0] next_pc = 32'hBFC0_0000;

  always #5 clk = ~clk;

  inst_fifo #(.DEPTH(DEPTH), .DW(32), .AW(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_inst1(write_inst1), .write_pc1(write_pc1), .write_adel1(write_adel1),
    .write_inst2(write_inst2), .write_pc2(write_pc2), .write_adel2(write_adel2),
    .read_en1(read_en1), .read_en2(read_en2),
    .master_inst(master_inst), .master_pc(master_pc), .master_adel(master_adel),
    .slave_inst(slave_inst), .slave_pc(slave_pc), .slave_adel(slave_adel),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty), .fifo_full(fifo_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t at(input int i);
    return (q.size() > i) ? q[i] : '0;
  endfunction

  task automatic check_all(input string tag);
    ent_t m, s;
    m = at(0);
    s = at(1);
    chk({tag, ".master_inst"}, 64'(master_inst), 64'(m.inst));
    chk({tag, ".master_pc"},   64'(master_pc),   64'(m.pc));
    chk({tag, ".master_adel"}, 64'(master_adel), 64'(m.adel));
    chk({tag, ".slave_inst"},  64'(slave_inst),  64'(s.inst));
    chk({tag, ".slave_pc"},    64'(slave_pc),    64'(s.pc));
    chk({tag, ".slave_adel"},  64'(slave_adel),  64'(s.adel));
    chk({tag, ".empty"},  64'(fifo_empty),        64'(q.size() == 0));
    chk({tag, ".aempty"}, 64'(fifo_almost_empty), 64'(q.size() == 1));
    chk({tag, ".full"},   64'(fifo_full),         64'(q.size() > DEPTH - 2));
  endtask

  task automatic set_ctrl(input bit fl, input bit we1, input bit we2, input bit re1, input bit re2);
    flush = fl; write_en1 = we1; write_en2 = we2; read_en1 = re1; read_en2 = re2;
    write_inst1 = $urandom; write_inst2 = $urandom;
    write_adel1 = 1'($urandom); write_adel2 = 1'($urandom);
    write_pc1 = next_pc; write_pc2 = next_pc + 32'd4;
    next_pc += 32'd8;
  endtask

  // Reference: pops (clamped) come off the front, then the push is all-or-nothing.
  task automatic model_update();
    int req, rn, wn;
    if (flush) begin
      q.delete();
      return;
    end
    req = int'(read_en1) + int'(read_en1 & read_en2);
    rn  = (req < q.size()) ? req : q.size();
    wn  = int'(write_en1) + int'(write_en1 & write_en2);
    repeat (rn) void'(q.pop_front());
    if (q.size() + wn <= DEPTH) begin
      if (wn >= 1) begin
        q.push_back('{write_inst1, write_pc1, write_adel1});
        if (rec) pushed.push_back(write_pc1);
      end
      if (wn == 2) begin
        q.push_back('{write_inst2, write_pc2, write_adel2});
        if (rec) pushed.push_back(write_pc2);
      end
    end
  endtask

  task automatic tick(input string tag);
    if (rec && !flush && read_en1 && q.size() >= 1) popped.push_back(master_pc);
    if (rec && !flush && read_en1 && read_en2 && q.size() >= 2) popped.push_back(slave_pc);
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  initial begin
    resetn = 1'b0;
    set_ctrl(0, 0, 0, 0, 0);
    #12;
    chk("reset.empty",  64'(fifo_empty), 64'd1);
    chk("reset.aempty", 64'(fifo_almost_empty), 64'd0);
    chk("reset.full",   64'(fifo_full), 64'd0);
    chk("reset.master_inst", 64'(master_inst), 64'd0);
    chk("reset.slave_inst",  64'(slave_inst), 64'd0);
    resetn = 1'b1;
    tick("idle");

    // Two-entry push, then a single pop.
    set_ctrl(0, 1, 1, 0, 0);
    write_inst1 = 32'h11; write_pc1 = 32'hBFC0_0000;
    write_inst2 = 32'h22; write_pc2 = 32'hBFC0_0004;
    tick("push2");
    chk("push2.master", 64'(master_inst), 64'h11);
    chk("push2.slave",  64'(slave_inst),  64'h22);
    chk("push2.aempty", 64'(fifo_almost_empty), 64'd0);
    set_ctrl(0, 0, 0, 1, 0);
    tick("pop1");
    chk("pop1.master", 64'(master_inst), 64'h22);
    chk("pop1.aempty", 64'(fifo_almost_empty), 64'd1);
    set_ctrl(0, 0, 0, 1, 1);
    tick("drain");

    // Fill to DEPTH-1, overflow drop, then push+pop at full.
    for (int i = 0; i < 7; i++) begin
      set_ctrl(0, 1, 1, 0, 0);
      tick("fill");
    end
    set_ctrl(0, 1, 0, 0, 0);
    tick("fill15");
    chk("fill15.full", 64'(fifo_full), 64'd1);
    set_ctrl(0, 1, 1, 0, 0);
    tick("drop");
    chk("drop.size", 64'(q.size()), 64'd15);
    set_ctrl(0, 1, 1, 1, 1);
    tick("full_pushpop");
    for (int i = 0; i < 9; i++) begin
      set_ctrl(0, 0, 0, 1, 1);
      tick("drain_full");
    end
    chk("drain_full.empty", 64'(fifo_empty), 64'd1);

    // Steady level of 5 across the wrap boundary; PCs out must equal PCs in.
    rec = 1'b1;
    pushed.delete(); popped.delete();
    set_ctrl(0, 1, 1, 0, 0); tick("lvl");
    set_ctrl(0, 1, 1, 0, 0); tick("lvl");
    set_ctrl(0, 1, 0, 0, 0); tick("lvl");
    for (int i = 0; i < 20; i++) begin
      set_ctrl(0, 1, 1, 1, 1);
      tick("steady");
    end
    chk("steady.npop", 64'(popped.size()), 64'd40);
    for (int i = 0; i < popped.size() && i < pushed.size(); i++)
      chk("steady.order", 64'(popped[i]), 64'(pushed[i]));
    rec = 1'b0;
    set_ctrl(1, 0, 0, 0, 0); tick("flush0");

    // Clamped double pop from a single entry.
    set_ctrl(0, 1, 0, 0, 0); tick("clamp_fill");
    set_ctrl(0, 0, 0, 1, 1); tick("clamp");
    chk("clamp.empty", 64'(fifo_empty), 64'd1);
    set_ctrl(0, 1, 1, 0, 0); tick("clamp_after");

    // Flush beats simultaneous push and pop.
    for (int i = 0; i < 3; i++) begin
      set_ctrl(0, 1, 1, 0, 0); tick("pre_flush");
    end
    set_ctrl(0, 1, 0, 0, 0); tick("pre_flush");
    set_ctrl(1, 1, 1, 1, 0); tick("flush");
    chk("flush.empty", 64'(fifo_empty), 64'd1);
    set_ctrl(0, 0, 0, 0, 0); tick("post_flush");

    // Asynchronous reset mid-cycle.
    set_ctrl(0, 1, 1, 0, 0); tick("pre_rst");
    set_ctrl(0, 1, 0, 0, 0); tick("pre_rst");
    #2 resetn = 1'b0;
    #1;
    q.delete();
    check_all("async_rst");
    #2 resetn = 1'b1;

    // Random traffic, biased to spend time near full.
    for (int i = 0; i < 400; i++) begin
      set_ctrl(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               ($urandom_range(0, 2) != 0), 1'($urandom));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
